rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 32x32 register file's single write port. Two writers compete for that port: the single-cycle execute path (A) and the long-latency load/multi-cycle unit (B). The block grants one request per cycle round-robin, registers the winning write onto the register-file write port, and tracks destinations of in-flight B operations so decode can stall on read-after-write hazards.

---
 rtl/rf_wb_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register-file write port.
// Define RF_WB_SCOREBOARD_EN to build the long-latency busy scoreboard and hazard output.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_wadd,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_wadd,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_wadd,
  input  logic [ADDR_W-1:0] radd1,
  input  logic [ADDR_W-1:0] radd2,
  output logic              hazard,
  output logic              rfwrite,
  output logic [ADDR_W-1:0] wadd,
  output logic [DATA_W-1:0] wdata
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic last_b_r;
  logic grant_a_s;
  logic grant_b_s;

  // Grant selection: a lone requester wins; a tie goes to whoever did not win last.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (a_valid && b_valid) begin
      if (last_b_r) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Write-port register and round-robin pointer; x0 writes are consumed without rfwrite.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_r <= 1'b1;
      rfwrite  <= 1'b0;
      wadd     <= ADDR_ZERO;
      wdata    <= DATA_ZERO;
    end else if (grant_a_s) begin
      last_b_r <= 1'b0;
      rfwrite  <= (a_wadd != ADDR_ZERO);
      wadd     <= a_wadd;
      wdata    <= a_wdata;
    end else if (grant_b_s) begin
      last_b_r <= 1'b1;
      rfwrite  <= (b_wadd != ADDR_ZERO);
      wadd     <= b_wadd;
      wdata    <= b_wdata;
    end else begin
      last_b_r <= last_b_r;
      rfwrite  <= 1'b0;
      wadd     <= wadd;
      wdata    <= wdata;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = {NREG{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next busy vector: clear applied before set so a same-cycle set wins; x0 never busy.
  always_comb begin
    set_mask_s    = sb_set    ? onehot(sb_wadd) : {NREG{1'b0}};
    clr_mask_s    = grant_b_s ? onehot(b_wadd)  : {NREG{1'b0}};
    busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_nxt_s[0] = 1'b0;
  end

  // Busy storage; no B clear is recorded while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign hazard = ((radd1 != ADDR_ZERO) && busy_r[radd1]) ||
                  ((radd2 != ADDR_ZERO) && busy_r[radd2]);
`else
  logic unused_sb_s;
  assign unused_sb_s = ^{sb_set, sb_wadd, radd1, radd2};
  assign hazard      = 1'b0;
`endif

endmodule
